// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Registered RV64I ALU decode stage with valid/ready in and out.
// Optional DECODE_SKID_BUF_EN: registered instr_ready_o backed by a one-entry skid buffer.
module decode_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] opr_a_o,
    output logic [XLEN-1:0] opr_b_o,
    output logic [3:0]      alu_func_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wr_en_o,
    output logic            illegal_o
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0] opr_a;
        logic [XLEN-1:0] opr_b;
        logic [3:0]      func;
        logic [4:0]      rd;
        logic            wr_en;
        logic            illegal;
    } bundle_t;

    localparam bundle_t BUNDLE_RST = '{opr_a: '0, opr_b: '0, func: OP_ADD, rd: '0, wr_en: 1'b0, illegal: 1'b0};

    function automatic logic [3:0] f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_op = OP_ADD;
            3'b001:  f3_op = OP_SLL;
            3'b010:  f3_op = OP_SLT;
            3'b011:  f3_op = OP_SLTU;
            3'b100:  f3_op = OP_XOR;
            3'b101:  f3_op = OP_SRL;
            3'b110:  f3_op = OP_OR;
            default: f3_op = OP_AND;
        endcase
    endfunction

    bundle_t         dec;
    bundle_t         out_q, out_d;
    logic            ex_valid_q, ex_valid_d;
    logic            accept;
    logic            legal;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_u;

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];
    assign f3         = instr_i[14:12];
    assign f7         = instr_i[31:25];
    assign imm_u      = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'h000};

    always_comb begin
        legal     = 1'b1;
        dec       = BUNDLE_RST;
        dec.rd    = instr_i[11:7];
        case (instr_i[6:0])
            7'b0110011: begin
                dec.opr_a = rs1_data_i;
                dec.opr_b = rs2_data_i;
                dec.func  = f3_op(f3);
                if (f7 == 7'b0100000 && f3 == 3'b000)      dec.func = OP_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101) dec.func = OP_SRA;
                else if (f7 != 7'b0000000)                 legal = 1'b0;
            end
            7'b0010011: begin
                dec.opr_a = rs1_data_i;
                dec.opr_b = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                dec.func  = f3_op(f3);
                // Shift immediates reuse imm[11:6] as a funct field; only shamt is the operand.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.opr_b = {{(XLEN-6){1'b0}}, instr_i[25:20]};
                    if (instr_i[31:26] == 6'b010000 && f3 == 3'b101) dec.func = OP_SRA;
                    else if (instr_i[31:26] != 6'b000000)            legal = 1'b0;
                end
            end
            7'b0110111: dec.opr_b = imm_u;
            7'b0010111: begin
                dec.opr_a = pc_i;
                dec.opr_b = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.opr_a = '0;
            dec.opr_b = '0;
            dec.func  = OP_ADD;
        end
        dec.illegal = !legal;
        dec.wr_en   = legal && (instr_i[11:7] != 5'd0);
    end

`ifdef DECODE_SKID_BUF_EN
    bundle_t skid_q, skid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    ready_q, ready_d;

    assign instr_ready_o = ready_q || flush_i;
    assign accept        = instr_valid_i && ready_q && !flush_i;

    always_comb begin
        out_d        = out_q;
        ex_valid_d   = ex_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            ex_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (ex_ready_i) begin
                out_d        = skid_q;
                ex_valid_d   = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!ex_valid_q || ex_ready_i) begin
                out_d      = dec;
                ex_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (ex_valid_q && ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_q       <= BUNDLE_RST;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end
`else
    assign instr_ready_o = !ex_valid_q || ex_ready_i || flush_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    always_comb begin
        out_d      = out_q;
        ex_valid_d = ex_valid_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            out_d      = dec;
            ex_valid_d = 1'b1;
        end else if (ex_valid_q && ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= BUNDLE_RST;
            ex_valid_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign opr_a_o    = out_q.opr_a;
    assign opr_b_o    = out_q.opr_b;
    assign alu_func_o = out_q.func;
    assign rd_addr_o  = out_q.rd;
    assign rd_wr_en_o = out_q.wr_en;
    assign illegal_o  = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - Randomized and directed checks of decode_stage against a queue-based model.
module tb_decode_stage;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3, OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_OR = 4'd8, OP_AND = 4'd9;
`ifdef DECODE_SKID_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr = 32'h0;
    logic [63:0] pc = 64'h0, rs1_data = 64'h0, rs2_data = 64'h0;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        flush = 1'b0, ex_ready = 1'b0;
    logic        ex_valid_o, rd_wr_en_o, illegal_o;
    logic [63:0] opr_a_o, opr_b_o;
    logic [3:0]  alu_func_o;

    decode_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready_o),
        .instr_i(instr), .pc_i(pc), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .flush_i(flush), .ex_valid_o(ex_valid_o),
        .ex_ready_i(ex_ready), .opr_a_o(opr_a_o), .opr_b_o(opr_b_o), .alu_func_o(alu_func_o),
        .rd_addr_o(rd_addr_o), .rd_wr_en_o(rd_wr_en_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  f;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  base_op [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    int          errors = 0;
    int          checks = 0;
    int          dut_acc = 0;
    logic        last_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decoding written as instruction-class rules on the raw word.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] p,
                                        input logic [63:0] r1, input logic [63:0] r2);
        exp_t e;
        logic ok = 1'b0;
        logic [2:0] fn3 = w[14:12];
        logic [6:0] fn7 = w[31:25];
        e.a = 64'h0; e.b = 64'h0; e.f = OP_ADD; e.rd = w[11:7];
        if (w[6:0] == 7'h33) begin
            e.a = r1; e.b = r2;
            if (fn7 == 7'h00) begin ok = 1'b1; e.f = base_op[fn3]; end
            else if (fn7 == 7'h20 && fn3 == 3'd0) begin ok = 1'b1; e.f = OP_SUB; end
            else if (fn7 == 7'h20 && fn3 == 3'd5) begin ok = 1'b1; e.f = OP_SRA; end
        end else if (w[6:0] == 7'h13) begin
            e.a = r1;
            if (fn3 == 3'd1 || fn3 == 3'd5) begin
                e.b = 64'(w[25:20]);
                if (w[31:26] == 6'd0) begin ok = 1'b1; e.f = base_op[fn3]; end
                else if (w[31:26] == 6'b010000 && fn3 == 3'd5) begin ok = 1'b1; e.f = OP_SRA; end
            end else begin
                ok = 1'b1; e.f = base_op[fn3];
                e.b = 64'($signed(w[31:20]));
            end
        end else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) begin
            ok = 1'b1;
            e.a = (w[6:0] == 7'h17) ? p : 64'h0;
            e.b = 64'($signed({w[31:12], 12'h000}));
        end
        if (!ok) begin e.a = 64'h0; e.b = 64'h0; e.f = OP_ADD; end
        e.ill = !ok;
        e.we = ok && (w[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic model_ready();
        if (CAP == 2) return flush || (q.size() < 2);
        return flush || (q.size() == 0) || ex_ready;
    endfunction

    task automatic cycle();
        logic mr;
        @(negedge clk);
        chk("instr_ready", 64'(instr_ready_o), 64'(model_ready()));
        chk("rs1_addr", 64'(rs1_addr_o), 64'(instr[19:15]));
        chk("rs2_addr", 64'(rs2_addr_o), 64'(instr[24:20]));
        chk("ex_valid", 64'(ex_valid_o), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("opr_a", opr_a_o, q[0].a);
            chk("opr_b", opr_b_o, q[0].b);
            chk("alu_func", 64'(alu_func_o), 64'(q[0].f));
            chk("rd_addr", 64'(rd_addr_o), 64'(q[0].rd));
            chk("rd_wr_en", 64'(rd_wr_en_o), 64'(q[0].we));
            chk("illegal", 64'(illegal_o), 64'(q[0].ill));
        end
        if (instr_valid && instr_ready_o && !flush) dut_acc++;
        @(posedge clk);
        mr = model_ready();
        last_acc = instr_valid && mr && !flush;
        if (flush) q.delete();
        else begin
            if (q.size() != 0 && ex_ready) void'(q.pop_front());
            if (last_acc) q.push_back(ref_decode(instr, pc, rs1_data, rs2_data));
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        logic [5:0]  top [3] = '{6'h00, 6'h10, 6'h00};
        f7s[3] = r[31:25];
        top[2] = r[31:26];
        case ($urandom_range(0, 5))
            0: return {f7s[$urandom_range(0, 3)], r[24:7], 7'h33};
            1: return {r[31:7], 7'h13};
            2: return {top[$urandom_range(0, 2)], r[25:20], r[19:15], ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd1, r[11:7], 7'h13};
            3: return {r[31:7], 7'h37};
            4: return {r[31:7], 7'h17};
            default: return r;
        endcase
    endfunction

    task automatic send_one(input logic [31:0] w, input logic [63:0] p, input logic [63:0] r1, input logic [63:0] r2);
        instr = w; pc = p; rs1_data = r1; rs2_data = r2;
        instr_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
        cycle();
        instr_valid = 1'b0;
        rs1_data = ~r1; rs2_data = ~r2;
    endtask

    task automatic lit_bundle(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [3:0] f,
                              input logic [4:0] rd, input logic we, input logic ill);
        chk({tag, "_valid"}, 64'(ex_valid_o), 64'd1);
        chk({tag, "_a"}, opr_a_o, a);
        chk({tag, "_b"}, opr_b_o, b);
        chk({tag, "_func"}, 64'(alu_func_o), 64'(f));
        chk({tag, "_rd"}, 64'(rd_addr_o), 64'(rd));
        chk({tag, "_we"}, 64'(rd_wr_en_o), 64'(we));
        chk({tag, "_ill"}, 64'(illegal_o), 64'(ill));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 64'(ex_valid_o), 64'd0);
        chk({tag, "_ready"}, 64'(instr_ready_o), 64'd1);
        chk({tag, "_a"}, opr_a_o, 64'd0);
        chk({tag, "_b"}, opr_b_o, 64'd0);
        chk({tag, "_func"}, 64'(alu_func_o), 64'(OP_ADD));
        chk({tag, "_rd"}, 64'(rd_addr_o), 64'd0);
        chk({tag, "_we"}, 64'(rd_wr_en_o), 64'd0);
        chk({tag, "_ill"}, 64'(illegal_o), 64'd0);
    endtask

    initial begin
        #1 check_reset_values("reset_init");
        @(posedge clk); #1 reset = 1'b0;

        send_one(32'h002081B3, 64'h0, 64'd5, 64'd7);
        lit_bundle("add", 64'd5, 64'd7, OP_ADD, 5'd3, 1'b1, 1'b0);
        send_one(32'hFFF00093, 64'h0, 64'd0, 64'd9);
        lit_bundle("addi", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, OP_ADD, 5'd1, 1'b1, 1'b0);
        send_one(32'h43F35293, 64'h0, 64'h1234, 64'd0);
        lit_bundle("srai", 64'h1234, 64'd63, OP_SRA, 5'd5, 1'b1, 1'b0);
        send_one(32'h80000117, 64'h1000, 64'd0, 64'd0);
        lit_bundle("auipc", 64'h1000, 64'hFFFF_FFFF_8000_0000, OP_ADD, 5'd2, 1'b1, 1'b0);
        send_one(32'h00000000, 64'h0, 64'd3, 64'd4);
        lit_bundle("ill_zero", 64'd0, 64'd0, OP_ADD, 5'd0, 1'b0, 1'b1);
        send_one(32'h022081B3, 64'h0, 64'd3, 64'd4);
        lit_bundle("ill_mul", 64'd0, 64'd0, OP_ADD, 5'd3, 1'b0, 1'b1);
        send_one(32'h47F35293, 64'h0, 64'd3, 64'd4);
        lit_bundle("ill_srai", 64'd0, 64'd0, OP_ADD, 5'd5, 1'b0, 1'b1);
        cycle();

        // Stall: one accepted bundle, then three cycles of back-pressure with fetch still offering.
        instr = rand_instr(); rs1_data = {$urandom, $urandom}; instr_valid = 1'b1; ex_ready = 1'b0;
        cycle();
        dut_acc = 0;
        for (int i = 0; i < 3; i++) begin
            if (last_acc) instr = rand_instr();
            rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
            cycle();
        end
        chk("stall_extra_accepts", 64'(dut_acc), 64'(CAP - 1));
        instr_valid = 1'b0; ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Flush while stalled with storage full.
        instr = rand_instr(); instr_valid = 1'b1; ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin cycle(); if (last_acc) instr = rand_instr(); end
        flush = 1'b1;
        cycle();
        flush = 1'b0; instr_valid = 1'b0;
        chk("flush_clears_valid", 64'(ex_valid_o), 64'd0);
        ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("flush_nothing_after", 64'(ex_valid_o), 64'd0);

        for (int i = 0; i < 600; i++) begin
            if (!instr_valid || last_acc) instr = rand_instr();
            instr_valid = ($urandom_range(0, 9) < 8);
            ex_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            pc = {$urandom, $urandom[31:2], 2'b00};
            rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
            cycle();
            if (i == 300) begin
                // Asynchronous reset mid-stream, well away from any clock edge.
                #2 reset = 1'b1;
                #1 check_reset_values("reset_async");
                q.delete(); last_acc = 1'b0;
                @(posedge clk); #1 reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered decode stage that produces the ALU-side interface consumed by execute: opr_a, opr_b, and a 4-bit alu_func using the OP_* codes from cpu_consts.
- Takes a fetched RV64 instruction and its PC through a valid/ready handshake.
- Drives register-file read addresses, captures the read data, and presents decoded operands to execute through a second valid/ready handshake.
- Supports flush for branch redirect.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
instr_valid_i  input  1  fetch has an instruction
instr_ready_o  output  1  decode can accept
instr_i  input  32  instruction word
pc_i  input  XLEN  PC of instr_i
rs1_addr_o  output  5  regfile read address 1, instr_i[19:15], combinational
rs2_addr_o  output  5  regfile read address 2, instr_i[24:20], combinational
rs1_data_i  input  XLEN  regfile read data 1, same-cycle async read
rs2_data_i  input  XLEN  regfile read data 2
flush_i  input  1  discard all held and incoming instructions
ex_valid_o  output  1  decoded bundle valid
ex_ready_i  input  1  execute accepts bundle
opr_a_o  output  XLEN  ALU operand A
opr_b_o  output  XLEN  ALU operand B
alu_func_o  output  4  OP_* code
rd_addr_o  output  5  destination register
rd_wr_en_o  output  1  writeback enable
illegal_o  output  1  instruction not decodable

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, mid-operation included, and forces:
  - ex_valid_o, opr_a_o, opr_b_o, rd_addr_o, rd_wr_en_o and illegal_o to 0.
  - alu_func_o to OP_ADD.
  - instr_ready_o to 1.
- Accept: instr_valid_i && instr_ready_o at a rising edge. Decode is combinational from instr_i, pc_i and rs*_data_i, and is registered at that edge.
- Latency: the bundle is visible with ex_valid_o=1 on the cycle after acceptance.
- instr_ready_o = !ex_valid_o || ex_ready_i (combinational). Back-to-back acceptance gives one instruction per cycle.
- While ex_valid_o && !ex_ready_i, every output register holds stable.
- Consume: when ex_valid_o && ex_ready_i with no new acceptance, ex_valid_o drops next cycle.
- flush_i:
  - ex_valid_o is 0 on the next cycle.
  - Any instruction accepted in the flush cycle is discarded.
  - instr_ready_o is forced to 1 during the flush cycle.
  - Flush wins over simultaneous accept and stall.
- Decode rules:
  - R-type (0110011), operands opr_a=rs1_data, opr_b=rs2_data. Mapping from funct7/funct3:
    - 0000000/000 → ADD; 0100000/000 → SUB.
    - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
    - 0000000/101 → SRL; 0100000/101 → SRA.
    - 110 → OR; 111 → AND.
    - Any other funct7/funct3 pairing is illegal, including 0000001 (M extension).
  - OP-IMM (0010011), opr_a=rs1_data, opr_b=sign-extended instr[31:20]. funct3 mapping as for R-type, with 000 → ADD.
  - Shift immediates: opr_b = zero-extended instr[25:20].
    - instr[31:26]=000000 gives SLLI or SRLI.
    - 010000 gives SRAI, valid only with funct3=101.
    - Anything else is illegal.
  - LUI (0110111): opr_a=0, opr_b=sign-extended {instr[31:12],12'b0}, func ADD.
  - AUIPC (0010111): opr_a=pc_i, opr_b as for LUI, func ADD.
  - All other opcodes are illegal.
- Illegal instruction:
  - illegal_o=1, rd_wr_en_o=0.
  - opr_a_o=opr_b_o=0, alu_func_o=OP_ADD.
  - ex_valid_o still asserts, so the trap logic sees it.
- rd_addr_o = instr[11:7]. rd_wr_en_o = legal && rd != 0.
- Operand data is sampled at acceptance only; the regfile changing later does not affect a held bundle.

Optional Feature:
Macro DECODE_SKID_BUF_EN.
- Defined:
  - instr_ready_o is a register.
  - A one-entry skid buffer holds the full decoded bundle.
  - When the output is stalled and ready was 1, the incoming bundle lands in the skid buffer and ready goes 0 next cycle.
  - When the output is consumed, the skid contents move to the output and ready returns to 1.
  - flush_i and reset empty the skid buffer.
  - Latency is unchanged, and ordering is preserved.
- Undefined: combinational ready as above, with no skid storage.

Test Plan:
1. add x3,x1,x2: instr 0x002081B3, rs1_data=5, rs2_data=7 → next cycle ex_valid_o=1, opr_a=5, opr_b=7, OP_ADD, rd=3, rd_wr_en=1, illegal=0.
2. addi x1,x0,-1: 0xFFF00093, rs1_data=0 → opr_a=0, opr_b=0xFFFF_FFFF_FFFF_FFFF, OP_ADD, rd=1.
3. srai x5,x6,63: 0x43F35293 → opr_b=63, OP_SRA, rd=5. auipc x2,0x80000: 0x80000117 with pc=0x1000 → opr_a=0x1000, opr_b=0xFFFF_FFFF_8000_0000, OP_ADD.
4. Hold ex_ready_i=0 for 3 cycles with a valid bundle and a stream of 3 instructions:
   - Outputs are stable throughout.
   - Without the macro, instr_ready_o=0 throughout; with the macro, exactly one extra instruction is accepted.
   - Release → all instructions exit in order, none lost or duplicated.
5. Illegal and reserved encodings → illegal_o=1, rd_wr_en_o=0, ex_valid_o=1:
   - 0x00000000.
   - add with funct7=0000001, i.e. 0x022081B3.
   - srai with instr[31:26]=010001, i.e. 0x47F35293.
6. Flush and reset:
   - flush_i during a stall with the skid buffer full → ex_valid_o=0 next cycle, nothing emitted afterwards.
   - Assert reset asynchronously mid-stream → outputs go to their reset values before the next clock edge.
